// File: rtl/sdrd_bmp_pixel_unpack.sv
// sdrd_bmp_pixel_unpack
//   Turns the SD reader's 64-bit word strobe into a stream of 24-bit BMP
//   pixels tagged with frame coordinates. Words are buffered in a small FIFO,
//   serialised LSB-byte first, grouped as B,G,R and stripped of row padding.
//   Rows arrive bottom-up, so y counts down from IMG_H-1 to 0.
//
// Ports
//   CLK, RST_X       clock, asynchronous active-low reset
//   WR, DATA         one-cycle word strobe; DATA[7:0] is the earliest byte
//   FRAME_START      flush everything and start a new frame
//   PIX_READY        downstream accepts the presented pixel
//   PIX_VALID        pixel outputs valid (held until PIX_READY)
//   PIX_RGB          {R,G,B}
//   PIX_X, PIX_Y     pixel column / row
//   FRAME_DONE       one-cycle pulse once the last row is finished
//   OVERFLOW         sticky: a word arrived while the FIFO was full
module sdrd_bmp_pixel_unpack #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          WR,
  input  logic [63:0]   DATA,
  input  logic          FRAME_START,
  input  logic          PIX_READY,
  output logic          PIX_VALID,
  output logic [23:0]   PIX_RGB,
  output logic [XW-1:0] PIX_X,
  output logic [YW-1:0] PIX_Y,
  output logic          FRAME_DONE,
  output logic          OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // BMP rows are padded to a multiple of 4 bytes.
  localparam int PAD = (4 - ((3 * IMG_W) % 4)) % 4;
  localparam bit HAS_PAD = (PAD != 0);
  localparam logic [1:0] PAD_LAST = HAS_PAD ? 2'(PAD - 1) : 2'd0;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYTE,
    ST_HOLD,
    ST_PAD,
    ST_DONE
  } state_t;

  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]   sr_q;
  logic [3:0]    sr_cnt_q;
  state_t        state_q;
  logic [1:0]    phase_q;
  logic [1:0]    pad_cnt_q;
  logic [7:0]    b_q, g_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          pix_valid_q;
  logic [23:0]   pix_rgb_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  logic          frame_done_q;
  logic          overflow_q;

  logic fifo_empty, fifo_full, sr_empty, pop, push, drop;
  logic [7:0] cur_byte;

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign sr_empty   = (sr_cnt_q == 4'd0);
  assign cur_byte   = sr_q[7:0];

  assign pop  = !FRAME_START && sr_empty && !fifo_empty &&
                ((state_q == ST_BYTE) || (state_q == ST_PAD));
  // A word arriving with FRAME_START always lands: the flush frees the FIFO.
  // A pop in the same cycle frees a slot for an otherwise-full FIFO.
  assign push = WR && (FRAME_START ||
                       ((state_q != ST_DONE) && (!fifo_full || pop)));
  assign drop = WR && !FRAME_START && (state_q != ST_DONE) &&
                fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= DATA;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sr_q         <= '0;
      sr_cnt_q     <= '0;
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      pad_cnt_q    <= '0;
      b_q          <= '0;
      g_q          <= '0;
      x_q          <= '0;
      y_q          <= Y_LAST;
      pix_valid_q  <= 1'b0;
      pix_rgb_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        sr_q     <= fifo_mem[rd_ptr_q[AW-1:0]];
        sr_cnt_q <= 4'd8;
      end
      if (drop) overflow_q <= 1'b1;

      if (FRAME_START) begin
        rd_ptr_q    <= wr_ptr_q;  // flush; a same-cycle word still gets pushed
        sr_cnt_q    <= '0;
        overflow_q  <= 1'b0;
        pix_valid_q <= 1'b0;
        phase_q     <= '0;
        pad_cnt_q   <= '0;
        x_q         <= '0;
        y_q         <= Y_LAST;
        state_q     <= ST_BYTE;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_BYTE: begin
            if (!sr_empty) begin
              sr_q     <= {8'h00, sr_q[63:8]};
              sr_cnt_q <= sr_cnt_q - 4'd1;
              case (phase_q)
                2'd0: begin
                  b_q     <= cur_byte;
                  phase_q <= 2'd1;
                end
                2'd1: begin
                  g_q     <= cur_byte;
                  phase_q <= 2'd2;
                end
                default: begin
                  pix_rgb_q   <= {cur_byte, g_q, b_q};
                  pix_x_q     <= x_q;
                  pix_y_q     <= y_q;
                  pix_valid_q <= 1'b1;
                  phase_q     <= 2'd0;
                  state_q     <= ST_HOLD;
                end
              endcase
            end
          end
          ST_HOLD: begin
            if (PIX_READY) begin
              pix_valid_q <= 1'b0;
              if (x_q != X_LAST) begin
                x_q     <= x_q + XW'(1);
                state_q <= ST_BYTE;
              end else begin
                x_q <= '0;
                if (HAS_PAD) begin
                  pad_cnt_q <= '0;
                  state_q   <= ST_PAD;
                end else if (y_q == '0) begin
                  frame_done_q <= 1'b1;
                  state_q      <= ST_DONE;
                end else begin
                  y_q     <= y_q - YW'(1);
                  state_q <= ST_BYTE;
                end
              end
            end
          end
          ST_PAD: begin
            if (!sr_empty) begin
              sr_q     <= {8'h00, sr_q[63:8]};
              sr_cnt_q <= sr_cnt_q - 4'd1;
              if (pad_cnt_q == PAD_LAST) begin
                if (y_q == '0) begin
                  frame_done_q <= 1'b1;
                  state_q      <= ST_DONE;
                end else begin
                  y_q     <= y_q - YW'(1);
                  state_q <= ST_BYTE;
                end
              end else begin
                pad_cnt_q <= pad_cnt_q + 2'd1;
              end
            end
          end
          ST_DONE: begin
            // Trailing data of the finished frame is thrown away.
            rd_ptr_q <= wr_ptr_q;
            sr_cnt_q <= '0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign PIX_VALID  = pix_valid_q;
  assign PIX_RGB    = pix_rgb_q;
  assign PIX_X      = pix_x_q;
  assign PIX_Y      = pix_y_q;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_sdrd_bmp_pixel_unpack.sv
module tb_sdrd_bmp_pixel_unpack;

  typedef struct packed {
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 3x2 (PAD=3), dut_b: 4x1 (PAD=0), dut_c: 16x1 with a 2-deep FIFO
  logic a_wr = 0, a_fs = 0, a_ready = 0;
  logic b_wr = 0, b_fs = 0, b_ready = 0;
  logic c_wr = 0, c_fs = 0, c_ready = 0;
  logic [63:0] a_data = '0, b_data = '0, c_data = '0;
  logic a_valid, b_valid, c_valid;
  logic [23:0] a_rgb, b_rgb, c_rgb;
  logic [9:0] a_x, b_x, c_x;
  logic [8:0] a_y, b_y, c_y;
  logic a_done, b_done, c_done, a_ovf, b_ovf, c_ovf;

  sdrd_bmp_pixel_unpack #(.IMG_W(3), .IMG_H(2), .XW(10), .YW(9), .FIFO_DEPTH(4)) dut_a (
    .CLK(clk), .RST_X(rst_n), .WR(a_wr), .DATA(a_data), .FRAME_START(a_fs),
    .PIX_READY(a_ready), .PIX_VALID(a_valid), .PIX_RGB(a_rgb), .PIX_X(a_x),
    .PIX_Y(a_y), .FRAME_DONE(a_done), .OVERFLOW(a_ovf));

  sdrd_bmp_pixel_unpack #(.IMG_W(4), .IMG_H(1), .XW(10), .YW(9), .FIFO_DEPTH(4)) dut_b (
    .CLK(clk), .RST_X(rst_n), .WR(b_wr), .DATA(b_data), .FRAME_START(b_fs),
    .PIX_READY(b_ready), .PIX_VALID(b_valid), .PIX_RGB(b_rgb), .PIX_X(b_x),
    .PIX_Y(b_y), .FRAME_DONE(b_done), .OVERFLOW(b_ovf));

  sdrd_bmp_pixel_unpack #(.IMG_W(16), .IMG_H(1), .XW(10), .YW(9), .FIFO_DEPTH(2)) dut_c (
    .CLK(clk), .RST_X(rst_n), .WR(c_wr), .DATA(c_data), .FRAME_START(c_fs),
    .PIX_READY(c_ready), .PIX_VALID(c_valid), .PIX_RGB(c_rgb), .PIX_X(c_x),
    .PIX_Y(c_y), .FRAME_DONE(c_done), .OVERFLOW(c_ovf));

  int checks = 0, errors = 0;
  pix_t a_q[$], b_q[$], c_q[$];
  int a_acc = 0, b_acc = 0, c_acc = 0;
  int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;
  bit a_stall = 0, b_stall = 0, c_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pix_t px(input logic [23:0] rgb, input int x, input int y);
    pix_t p;
    p.rgb = rgb;
    p.x   = 10'(x);
    p.y   = 9'(y);
    return p;
  endfunction

  // Word whose bytes are base, base+1, ... base+7 (earliest byte in [7:0]).
  function automatic logic [63:0] wd(input int base);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(base + i);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus on DUT d (0=a, 1=b, 2=c).
  task automatic drive(input int d, input bit fs, input bit wr, input logic [63:0] v);
    case (d)
      0: begin a_fs = fs; a_wr = wr; a_data = v; end
      1: begin b_fs = fs; b_wr = wr; b_data = v; end
      default: begin c_fs = fs; c_wr = wr; c_data = v; end
    endcase
    tick();
    a_fs = 0; a_wr = 0; b_fs = 0; b_wr = 0; c_fs = 0; c_wr = 0;
  endtask

  task automatic wait_done(input int d, input int target, input string name);
    int n, qs;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      n = (d == 0) ? a_done_cnt : (d == 1) ? b_done_cnt : c_done_cnt;
      if (n >= target) break;
      tick();
    end
    repeat (4) tick();
    n  = (d == 0) ? a_done_cnt : (d == 1) ? b_done_cnt : c_done_cnt;
    qs = (d == 0) ? a_q.size() : (d == 1) ? b_q.size() : c_q.size();
    chk({name, "_frame_done_count"}, n, target);
    chk({name, "_pixels_outstanding"}, qs, 0);
  endtask

  task automatic push_a_std();
    a_q.push_back(px(24'h020100, 0, 1));
    a_q.push_back(px(24'h050403, 1, 1));
    a_q.push_back(px(24'h080706, 2, 1));
    a_q.push_back(px(24'h0E0D0C, 0, 0));
    a_q.push_back(px(24'h11100F, 1, 0));
    a_q.push_back(px(24'h141312, 2, 0));
  endtask

  // Monitors: compare every presented pixel with the queue head, pop on accept.
  always @(negedge clk) begin
    if (!rst_n) a_stall = 0;
    else begin
      if (a_done) a_done_cnt++;
      if (a_stall) chk("a_valid_held", a_valid, 1);
      if (a_valid) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_pixel: got rgb=%06h x=%0d y=%0d, expected none", a_rgb, a_x, a_y);
        end else begin
          chk("a_rgb", a_rgb, a_q[0].rgb);
          chk("a_x", a_x, a_q[0].x);
          chk("a_y", a_y, a_q[0].y);
          if (a_ready) begin
            void'(a_q.pop_front());
            a_acc++;
            $display("a pixel x=%0d y=%0d rgb=%06h", a_x, a_y, a_rgb);
          end
        end
      end
      a_stall = a_valid && !a_ready;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) b_stall = 0;
    else begin
      if (b_done) b_done_cnt++;
      if (b_stall) chk("b_valid_held", b_valid, 1);
      if (b_valid) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_pixel: got rgb=%06h x=%0d y=%0d, expected none", b_rgb, b_x, b_y);
        end else begin
          chk("b_rgb", b_rgb, b_q[0].rgb);
          chk("b_x", b_x, b_q[0].x);
          chk("b_y", b_y, b_q[0].y);
          if (b_ready) begin
            void'(b_q.pop_front());
            b_acc++;
            $display("b pixel x=%0d y=%0d rgb=%06h", b_x, b_y, b_rgb);
          end
        end
      end
      b_stall = b_valid && !b_ready;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) c_stall = 0;
    else begin
      if (c_done) c_done_cnt++;
      if (c_stall) chk("c_valid_held", c_valid, 1);
      if (c_valid) begin
        if (c_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_extra_pixel: got rgb=%06h x=%0d y=%0d, expected none", c_rgb, c_x, c_y);
        end else begin
          chk("c_rgb", c_rgb, c_q[0].rgb);
          chk("c_x", c_x, c_q[0].x);
          chk("c_y", c_y, c_q[0].y);
          if (c_ready) begin
            void'(c_q.pop_front());
            c_acc++;
            $display("c pixel x=%0d y=%0d rgb=%06h", c_x, c_y, c_rgb);
          end
        end
      end
      c_stall = c_valid && !c_ready;
    end
  end

  initial begin
    bit found;
    int base;

    // Reset state
    repeat (3) tick();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_rgb", a_rgb, 0);
    chk("rst_a_x", a_x, 0);
    chk("rst_a_y", a_y, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_c_valid", c_valid, 0);
    rst_n = 1'b1;
    tick();

    // Basic 3x2 frame with padding stripped
    a_ready = 1;
    push_a_std();
    drive(0, 1, 0, '0);
    drive(0, 0, 1, wd(8'h00));
    drive(0, 0, 1, wd(8'h08));
    drive(0, 0, 1, wd(8'h10));
    wait_done(0, 1, "t1");
    drive(0, 0, 1, wd(8'h20));   // ignored once the frame is done
    repeat (20) tick();
    chk("t1_done_valid_low", a_valid, 0);
    chk("t1_done_single_pulse", a_done_cnt, 1);
    chk("t1_done_no_ovf", a_ovf, 0);

    // Backpressure at pixel (1,1)
    push_a_std();
    drive(0, 1, 0, '0);
    drive(0, 0, 1, wd(8'h00));
    drive(0, 0, 1, wd(8'h08));
    drive(0, 0, 1, wd(8'h10));
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_valid && a_x == 10'd1 && a_y == 9'd1) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t2_stall_pixel_seen", found, 1);
    a_ready = 0;
    repeat (10) tick();
    chk("t2_hold_valid", a_valid, 1);
    chk("t2_hold_rgb", a_rgb, 24'h050403);
    chk("t2_hold_x", a_x, 1);
    chk("t2_hold_y", a_y, 1);
    a_ready = 1;
    wait_done(0, 2, "t2");

    // Overflow: 4-deep FIFO stalled by PIX_READY=0, 6 back-to-back words
    a_ready = 0;
    push_a_std();
    drive(0, 1, 0, '0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 1, wd(8 * k));
      if (k == 4) chk("t3_ovf_before_full", a_ovf, 0);
      if (k == 5) chk("t3_ovf_set", a_ovf, 1);
    end
    repeat (3) tick();
    chk("t3_ovf_sticky", a_ovf, 1);
    a_ready = 1;
    wait_done(0, 3, "t3");
    chk("t3_ovf_after_frame", a_ovf, 1);
    drive(0, 1, 0, '0);
    chk("t3_ovf_cleared", a_ovf, 0);

    // Mid-frame FRAME_START after two pixels, new stream 0x80..
    a_q.push_back(px(24'h020100, 0, 1));
    a_q.push_back(px(24'h050403, 1, 1));
    base = a_acc;
    drive(0, 1, 0, '0);
    drive(0, 0, 1, wd(8'h00));
    drive(0, 0, 1, wd(8'h08));
    drive(0, 0, 1, wd(8'h10));
    for (int i = 0; i < 100; i++) begin
      if (a_acc >= base + 2) break;
      tick();
    end
    chk("t5_old_pixels_taken", a_acc - base, 2);
    a_q.push_back(px(24'h828180, 0, 1));
    a_q.push_back(px(24'h858483, 1, 1));
    a_q.push_back(px(24'h888786, 2, 1));
    a_q.push_back(px(24'h8E8D8C, 0, 0));
    a_q.push_back(px(24'h91908F, 1, 0));
    a_q.push_back(px(24'h949392, 2, 0));
    drive(0, 1, 1, wd(8'h80));   // word alongside FRAME_START is kept
    drive(0, 0, 1, wd(8'h88));
    drive(0, 0, 1, wd(8'h90));
    wait_done(0, 4, "t5");

    // 4x1, no padding
    b_ready = 1;
    b_q.push_back(px(24'h020100, 0, 0));
    b_q.push_back(px(24'h050403, 1, 0));
    b_q.push_back(px(24'h080706, 2, 0));
    b_q.push_back(px(24'h0B0A09, 3, 0));
    drive(1, 1, 0, '0);
    drive(1, 0, 1, wd(8'h00));
    drive(1, 0, 1, wd(8'h08));
    wait_done(1, 1, "t6");
    drive(1, 0, 1, wd(8'h10));
    repeat (20) tick();
    chk("t6_valid_stays_low", b_valid, 0);
    chk("t6_ovf", b_ovf, 0);

    // Write into a full 2-deep FIFO exactly on the cycle it pops
    for (int i = 0; i < 16; i++)
      c_q.push_back(px({8'(3*i + 2), 8'(3*i + 1), 8'(3*i)}, i, 0));
    c_ready = 0;
    drive(2, 1, 0, '0);
    drive(2, 0, 1, wd(0));
    drive(2, 0, 1, wd(8));
    drive(2, 0, 1, wd(16));      // FIFO now full, 5 bytes left in the shifter
    tick();
    tick();
    c_ready = 1;
    repeat (7) tick();
    drive(2, 0, 1, wd(24));      // lands on the pop of word 1
    chk("t4_ovf_on_pop_write", c_ovf, 0);
    repeat (15) tick();
    drive(2, 0, 1, wd(32));
    repeat (11) tick();
    drive(2, 0, 1, wd(40));
    wait_done(2, 1, "t4");
    chk("t4_ovf_final", c_ovf, 0);

    // Asynchronous reset while a pixel is being held
    a_ready = 0;
    a_q.push_back(px(24'h020100, 0, 1));
    drive(0, 1, 1, wd(8'h00));
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t7_pixel_before_reset", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", a_valid, 0);
    chk("t7_async_rgb", a_rgb, 0);
    chk("t7_async_x", a_x, 0);
    chk("t7_async_y", a_y, 0);
    chk("t7_async_ovf", a_ovf, 0);
    a_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t7_idle_after_reset", a_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrd_bmp_pixel_unpack.md
Name: sdrd_bmp_pixel_unpack

Overview:
- Downstream consumer of the SD reader's 64-bit data strobe (WR/DATA).
- Buffers incoming 64-bit words in a small FIFO and serialises them into bytes.
- Assembles 24-bit BMP pixels (byte order B,G,R) and strips BMP row padding.
- Emits one pixel at a time with frame X/Y coordinates under a valid/ready handshake, for a frame-buffer writer.
- Input stream is pixel-array data only; the header has already been skipped by the FAT32/SPI control path.

Parameters:
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- XW, 10, width of PIX_X.
- YW, 9, width of PIX_Y.
- FIFO_DEPTH, 4, number of 64-bit words buffered; must be a power of 2, ≥2.

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  asynchronous active-low reset.
- WR  in  1  one-cycle strobe: DATA valid this cycle.
- DATA  in  64  stream word; DATA[7:0] is the earliest stream byte, DATA[63:56] the latest.
- FRAME_START  in  1  one-cycle pulse: flush and restart a frame.
- PIX_READY  in  1  downstream accepts pixel.
- PIX_VALID  out  1  pixel outputs valid.
- PIX_RGB  out  24  {R,G,B}.
- PIX_X  out  XW  column, 0..IMG_W-1.
- PIX_Y  out  YW  row, 0..IMG_H-1.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel is accepted.
- OVERFLOW  out  1  sticky: a WR word was dropped.

Behaviour:
- Reset: all outputs 0. FIFO empty. State IDLE. x=0, y=IMG_H-1, byte phase 0.
- Padding: PAD = (4 - (3*IMG_W mod 4)) mod 4, computed at elaboration.
- FIFO write:
  - WR with FIFO not full: word pushed.
  - WR with FIFO full and no pop this cycle: word dropped, OVERFLOW set.
  - WR with FIFO full and a pop in the same cycle: word accepted.
- FIFO pop: a word is popped into an internal 64-bit shift register when the shift register is empty and the state is BYTE or PAD.
- States:
  - IDLE: waits for FRAME_START; WR words are still buffered. FRAME_START → BYTE.
  - BYTE: consumes one byte per cycle from the shift register (stalls if empty). Phase 0 → B, 1 → G, 2 → R. After the R byte: PIX_VALID=1 next cycle, → HOLD.
  - HOLD: PIX_VALID, PIX_RGB, PIX_X and PIX_Y stay stable until PIX_READY. On PIX_VALID&&PIX_READY:
    - If x<IMG_W-1: x++, → BYTE.
    - Else: x=0; → PAD if PAD≠0, else end-of-row handling.
  - PAD: discards PAD bytes, one per cycle, stalling on an empty shift register; then end-of-row handling.
  - End of row: if y==0, FRAME_DONE pulse → DONE; else y--, → BYTE.
  - DONE: remaining shift-register and FIFO contents are discarded; incoming WR is ignored. FRAME_START → BYTE.
- Row order: BMP is bottom-up, so the first pixel emitted is (0, IMG_H-1).
- Bytes remaining in the current word after a row continue into the next row; no realignment at row boundaries.
- Latency: first pixel PIX_VALID no earlier than 5 cycles after the first WR (push, pop, 3 bytes).
- FRAME_START in any state, mid-frame included:
  - Flushes the FIFO and shift register.
  - Clears OVERFLOW, PIX_VALID and phase.
  - Resets x=0, y=IMG_H-1, → BYTE.
  - A WR in the same cycle is kept, as the first word of the new frame.
- Width rules: x and y compare against IMG_W-1 and IMG_H-1 truncated to XW and YW. Counters never wrap past these bounds.
- Async reset mid-operation returns immediately to the reset state.

Test Plan:
- IMG_W=3, IMG_H=2 (PAD=3); FRAME_START; 3 WR words, bytes 0x00..0x17 ascending, PIX_READY=1.
  - Pixels out: (0,1)=0x020100, (1,1)=0x050403, (2,1)=0x080706.
  - Then, skipping bytes 09..0B: (0,0)=0x0E0D0C, (1,0)=0x11100F, (2,0)=0x141312.
  - FRAME_DONE pulses once; bytes 15..17 are pad.
- Backpressure: same stream with PIX_READY low for 10 cycles at pixel (1,1) → PIX_RGB and PIX_X/PIX_Y hold 0x050403, 1, 1; no byte lost.
- Overflow: FIFO_DEPTH=4, PIX_READY=0, 6 consecutive WR → OVERFLOW=1 after the word that finds the FIFO full. Only that and later words are dropped, never earlier ones. FRAME_START clears OVERFLOW to 0.
- Simultaneous WR on a full FIFO with a pop → word accepted, OVERFLOW stays 0.
- Mid-frame FRAME_START after 2 pixels with a new stream → first pixel is (0,IMG_H-1) built from new-stream bytes only.
- IMG_W=4, IMG_H=1 (PAD=0), 2 words → 4 pixels, x 0..3, y=0, then FRAME_DONE. A subsequent WR is ignored; PIX_VALID stays 0.
